// File: rtl/fwrisc_csr_exec.sv
// fwrisc_csr_exec: multi-cycle CSR read-modify-write sequencer.
// Owns the register-file port for one CSRRW/CSRRS/CSRRC/CSRR instruction:
// read the CSR, compute the new value, write the CSR, write rd, respond.
// All outputs are registered; they are loaded with the values that belong
// to the state being entered.
module fwrisc_csr_exec #(
  parameter bit          ENABLE_WRITE_PROTECT = 1'b1,
  parameter logic [63:0] CSR_RO_MASK          = 64'h0010_021E_0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [5:0]  req_csr,
  input  logic [31:0] req_wdata,
  input  logic        req_wdata_zero,
  input  logic [5:0]  req_rd,
  output logic        rsp_valid,
  output logic        rsp_illegal,
  output logic [31:0] rsp_rdata,
  output logic [5:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_wen
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CALC = 3'd2,
    WCSR = 3'd3,
    WGPR = 3'd4,
    RSP  = 3'd5
  } state_t;

  // Write intent: RW always writes; RS/RC write only with a non-zero source.
  function automatic logic write_intent(input logic [1:0] op, input logic src_zero);
    write_intent = (op == 2'b01) || (op[1] && !src_zero);
  endfunction

  // New CSR value from the old value and the source operand (bitwise only).
  function automatic logic [31:0] csr_update(input logic [1:0] op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] src);
    case (op)
      2'b01:   csr_update = src;
      2'b10:   csr_update = old_val | src;
      2'b11:   csr_update = old_val & ~src;
      default: csr_update = old_val;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [5:0]  csr_q, csr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [5:0]  rd_q, rd_d;
  logic [31:0] old_q, old_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [5:0]  rf_raddr_q, rf_raddr_d;
  logic [5:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        rf_wen_q, rf_wen_d;

  logic        req_wr_s;
  logic        req_illegal_s;

  // Classify the incoming request; only meaningful at acceptance.
  always_comb begin
    req_wr_s      = write_intent(req_op, req_wdata_zero);
    req_illegal_s = (req_csr < 6'h20) ||
                    (ENABLE_WRITE_PROTECT && req_wr_s && CSR_RO_MASK[req_csr]);
  end

  // Next-state and next-output logic for the CSR sequence.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    csr_d         = csr_q;
    wdata_d       = wdata_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    old_d         = old_q;
    rsp_valid_d   = 1'b0;
    rsp_illegal_d = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rf_raddr_d    = 6'd0;
    rf_waddr_d    = 6'd0;
    rf_wdata_d    = 32'd0;
    rf_wen_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d    = req_op;
          csr_d   = req_csr;
          wdata_d = req_wdata;
          wr_d    = req_wr_s;
          rd_d    = req_rd;
          if (req_illegal_s) begin
            state_d       = RSP;
            rsp_valid_d   = 1'b1;
            rsp_illegal_d = 1'b1;
            rsp_rdata_d   = 32'd0;
          end else begin
            state_d    = RD;
            rf_raddr_d = req_csr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        state_d = CALC;
      end
      CALC: begin
        // Read data is valid now; capture it and stage the CSR write.
        old_d      = rf_rdata;
        state_d    = WCSR;
        rf_wen_d   = wr_q;
        rf_waddr_d = csr_q;
        rf_wdata_d = csr_update(op_q, rf_rdata, wdata_q);
      end
      WCSR: begin
        state_d    = WGPR;
        rf_wen_d   = (rd_q != 6'd0);
        rf_waddr_d = rd_q;
        rf_wdata_d = old_q;
      end
      WGPR: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = old_q;
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      op_q          <= 2'd0;
      csr_q         <= 6'd0;
      wdata_q       <= 32'd0;
      wr_q          <= 1'b0;
      rd_q          <= 6'd0;
      old_q         <= 32'd0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rf_raddr_q    <= 6'd0;
      rf_waddr_q    <= 6'd0;
      rf_wdata_q    <= 32'd0;
      rf_wen_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      csr_q         <= csr_d;
      wdata_q       <= wdata_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      old_q         <= old_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rf_raddr_q    <= rf_raddr_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      rf_wen_q      <= rf_wen_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rf_raddr    = rf_raddr_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign rf_wen      = rf_wen_q;

endmodule

// File: tb/tb_fwrisc_csr_exec.sv
// Testbench for fwrisc_csr_exec: a simple 64-entry register file model
// answers the DUT's port; a reference array tracks the architectural
// effect of each CSR instruction and per-cycle port activity is checked.
module tb_fwrisc_csr_exec;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [5:0]  req_csr = 6'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_wdata_zero = 1'b0;
  logic [5:0]  req_rd = 6'd0;
  logic        rsp_valid;
  logic        rsp_illegal;
  logic [31:0] rsp_rdata;
  logic [5:0]  rf_raddr;
  logic [31:0] rf_rdata = 32'd0;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;

  fwrisc_csr_exec dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_csr        (req_csr),
    .req_wdata      (req_wdata),
    .req_wdata_zero (req_wdata_zero),
    .req_rd         (req_rd),
    .rsp_valid      (rsp_valid),
    .rsp_illegal    (rsp_illegal),
    .rsp_rdata      (rsp_rdata),
    .rf_raddr       (rf_raddr),
    .rf_rdata       (rf_rdata),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .rf_wen         (rf_wen)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] regs  [64];
  logic [31:0] model [64];
  logic        pre_en   = 1'b0;
  logic [5:0]  pre_addr = 6'd0;
  logic [31:0] pre_data = 32'd0;

  // Cycle counter used to measure acceptance spacing.
  always @(posedge clock) cyc <= cyc + 1;

  // Register file model: registered read, write port, bench preload port.
  always @(posedge clock) begin
    rf_rdata <= regs[rf_raddr];
    if (pre_en) regs[pre_addr] <= pre_data;
    else if (rf_wen) regs[rf_waddr] <= rf_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit is_ro(input logic [5:0] csr);
    return (csr == 6'h21) || (csr == 6'h22) || (csr == 6'h23) ||
           (csr == 6'h24) || (csr == 6'h29) || (csr == 6'h34);
  endfunction

  // Preload one register in both the regfile model and the reference.
  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_en = 1'b0;
    model[a] = d;
  endtask

  // Issue one request at a negedge and check the whole transaction.
  // Returns with the bench at the negedge where req_ready is back high.
  task automatic run_req(input logic [1:0] op, input logic [5:0] csr,
                         input logic [31:0] wdata, input logic zero,
                         input logic [5:0] rd, input bit hold,
                         output int acc, output bit was_ill);
    bit wr, ill;
    logic [31:0] old_v, new_v;
    int w;
    wr  = (op == 2'b01) || ((op == 2'b10 || op == 2'b11) && !zero);
    ill = (csr < 6'h20) || (wr && is_ro(csr));
    old_v = model[csr];
    if (op == 2'b01) new_v = wdata;
    else if (op == 2'b10) new_v = old_v | wdata;
    else new_v = old_v & ~wdata;
    was_ill = ill;

    req_valid = 1'b1; req_op = op; req_csr = csr;
    req_wdata = wdata; req_wdata_zero = zero; req_rd = rd;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      acc = cyc;
      return;
    end
    @(negedge clock);
    acc = cyc;
    if (!hold) req_valid = 1'b0;

    if (ill) begin
      chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("ill_rsp_illegal", 32'(rsp_illegal), 32'd1);
      chk("ill_rsp_rdata", rsp_rdata, 32'd0);
      chk("ill_wen", 32'(rf_wen), 32'd0);
      @(negedge clock);
      chk("ill_ready_back", 32'(req_ready), 32'd1);
      chk("ill_rsp_pulse", 32'(rsp_valid), 32'd0);
      chk("ill_wen2", 32'(rf_wen), 32'd0);
    end else begin
      chk("rd_raddr", 32'(rf_raddr), 32'(csr));
      chk("rd_wen", 32'(rf_wen), 32'd0);
      chk("rd_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
      chk("calc_raddr", 32'(rf_raddr), 32'd0);
      chk("calc_wen", 32'(rf_wen), 32'd0);
      @(negedge clock);
      chk("wcsr_wen", 32'(rf_wen), 32'(wr));
      if (wr) begin
        chk("wcsr_waddr", 32'(rf_waddr), 32'(csr));
        chk("wcsr_wdata", rf_wdata, new_v);
      end
      @(negedge clock);
      chk("wgpr_wen", 32'(rf_wen), 32'(rd != 6'd0));
      if (rd != 6'd0) begin
        chk("wgpr_waddr", 32'(rf_waddr), 32'(rd));
        chk("wgpr_wdata", rf_wdata, old_v);
      end
      @(negedge clock);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_illegal", 32'(rsp_illegal), 32'd0);
      chk("rsp_rdata", rsp_rdata, old_v);
      chk("rsp_wen", 32'(rf_wen), 32'd0);
      chk("rsp_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
      chk("idle_ready", 32'(req_ready), 32'd1);
      chk("idle_rsp_pulse", 32'(rsp_valid), 32'd0);
      chk("idle_rdata_hold", rsp_rdata, old_v);
      if (wr) model[csr] = new_v;
      if (rd != 6'd0) model[rd] = old_v;
    end
  endtask

  initial begin
    int a0, a1, prev_acc;
    bit il0, il1, prev_ill, prev_hold;
    logic [1:0] op;
    logic [5:0] csr, rd;
    logic [31:0] wd;
    logic zero;
    bit hold;

    // Reset held while the register file is filled.
    @(negedge clock);
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_wen", 32'(rf_wen), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_raddr", 32'(rf_raddr), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset_ready", 32'(req_ready), 32'd1);

    // Directed cases.
    preload(6'h31, 32'h0000_1234);
    run_req(2'b01, 6'h31, 32'hDEAD_BEEF, 1'b0, 6'd5, 1'b0, a0, il0);
    preload(6'h2D, 32'h0000_000F);
    run_req(2'b10, 6'h2D, 32'h0000_00F0, 1'b0, 6'd3, 1'b0, a0, il0);
    chk("csrrs_result", model[6'h2D], 32'h0000_00FF);
    preload(6'h38, 32'hA5A5_0001);
    run_req(2'b11, 6'h38, 32'd0, 1'b1, 6'd0, 1'b0, a0, il0);
    preload(6'h21, 32'h0000_0F1E);
    run_req(2'b01, 6'h21, 32'h1111_2222, 1'b0, 6'd4, 1'b0, a0, il0);
    chk("ro_write_illegal", 32'(il0), 32'd1);
    run_req(2'b00, 6'h21, 32'd0, 1'b1, 6'd6, 1'b0, a0, il0);
    run_req(2'b10, 6'h22, 32'h0000_0001, 1'b0, 6'd7, 1'b0, a0, il0);
    run_req(2'b11, 6'h29, 32'd0, 1'b1, 6'd8, 1'b0, a0, il0);
    run_req(2'b00, 6'h05, 32'd0, 1'b1, 6'd9, 1'b0, a0, il0);
    run_req(2'b01, 6'h3E, 32'h0000_0001, 1'b0, 6'd10, 1'b0, a0, il0);

    // Back-to-back: request held during the sequence, next taken at N+6.
    run_req(2'b01, 6'h30, 32'h5555_AAAA, 1'b0, 6'd11, 1'b1, a0, il0);
    run_req(2'b10, 6'h32, 32'h0F0F_0000, 1'b0, 6'd12, 1'b0, a1, il1);
    chk("b2b_gap", 32'(a1 - a0), 32'd6);

    // Randomized sequence; held requests expose the acceptance spacing.
    prev_hold = 1'b0; prev_acc = 0; prev_ill = 1'b0;
    for (int t = 0; t < 60; t++) begin
      op   = 2'($urandom_range(0, 3));
      csr  = 6'($urandom_range(0, 63));
      zero = ($urandom_range(0, 3) == 0);
      wd   = zero ? 32'd0 : $urandom;
      rd   = 6'($urandom_range(0, 31));
      hold = ($urandom_range(0, 1) == 1);
      run_req(op, csr, wd, zero, rd, hold, a1, il1);
      if (prev_hold) chk("rand_gap", 32'(a1 - prev_acc), prev_ill ? 32'd2 : 32'd6);
      prev_hold = hold; prev_acc = a1; prev_ill = il1;
    end
    req_valid = 1'b0;
    @(negedge clock);

    // Reset in the middle of the CSR write: abort with no further activity.
    preload(6'h33, 32'h0000_7777);
    req_valid = 1'b1; req_op = 2'b01; req_csr = 6'h33;
    req_wdata = 32'hCAFE_F00D; req_wdata_zero = 1'b0; req_rd = 6'd13;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("abort_wcsr_wen", 32'(rf_wen), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_wen_drop", 32'(rf_wen), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    chk("abort_wdata", rf_wdata, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_ready_back", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_no_wen", 32'(rf_wen), 32'd0);
      @(negedge clock);
    end

    // Final architectural state must match the reference.
    for (int i = 0; i < 64; i++) chk($sformatf("reg_%0d", i), regs[i], model[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fwrisc_csr_exec.md
Name: fwrisc_csr_exec

Overview:
- Executes CSRRW/CSRRS/CSRRC/CSRR as a multi-cycle read-modify-write sequence.
- Acts as the initiator on the register-file access port. It drives the read address, consumes the registered read data one cycle later, then writes the CSR and the destination GPR through the shared write port.
- Sits between the decode/execute stage and fwrisc_regfile, owning the rf_* port for the duration of one CSR instruction.

Parameters:
- ENABLE_WRITE_PROTECT, 1: when 1, write-intent accesses to read-only CSRs are rejected as illegal.
- CSR_RO_MASK, 64'h0010_021E_0000_0000: bit i set means CSR index i is read-only (0x21-0x24, 0x29, 0x34).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE and reset deasserted
- req_op  in  2  00 CSRR (read only), 01 RW, 10 RS, 11 RC
- req_csr  in  6  CSR index into the 64-entry register space
- req_wdata  in  32  rs1 value or zero-extended uimm
- req_wdata_zero  in  1  source field is x0 / uimm==0
- req_rd  in  6  destination GPR index (0..31)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_illegal  out  1  qualifies rsp_valid: illegal instruction
- rsp_rdata  out  32  old CSR value (0 when illegal)
- rf_raddr  out  6  regfile read address
- rf_rdata  in  32  regfile read data, registered (valid 1 cycle after rf_raddr)
- rf_waddr  out  6  regfile write address
- rf_wdata  out  32  regfile write data
- rf_wen  out  1  regfile write enable

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; req_ready=0 while asserted.
  - rsp_valid, rsp_illegal, rf_wen=0; rsp_rdata, rf_raddr, rf_waddr, rf_wdata=0.
  - Assertion mid-sequence aborts immediately. No further rf_wen pulse, no rsp.
- States: IDLE, RD, CALC, WCSR, WGPR, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge N, latch op, csr, wdata, wdata_zero and rd.
- Write intent: wr = (op==01) || (op[1] && !wdata_zero).
- Illegal: req_csr < 6'h20, or (ENABLE_WRITE_PROTECT && wr && CSR_RO_MASK[req_csr]).
  - Evaluated at acceptance.
  - Illegal requests go IDLE->RSP, giving rsp_valid at N+1 with rsp_illegal=1 and rsp_rdata=0.
  - No rf_wen is issued for illegal requests.
- Legal sequence:
  - RD (cycle N+1): rf_raddr=csr.
  - CALC (N+2): sample rf_rdata into old.
    - new = wdata (RW), old|wdata (RS), old&~wdata (RC).
  - WCSR (N+3): rf_wen=wr, rf_waddr=csr, rf_wdata=new.
  - WGPR (N+4): rf_wen=(rd!=0), rf_waddr=rd, rf_wdata=old.
  - RSP (N+5): rsp_valid=1, rsp_illegal=0, rsp_rdata=old.
  - Then IDLE. req_ready is high again in cycle N+6.
- Fixed latency: legal 5 cycles, illegal 1 cycle. Skipped writes still consume their state cycle.
- rf_wen is asserted at most once per write state and never in IDLE, RD, CALC or RSP. rf_raddr=0 outside RD.
- rsp_rdata holds its value until the next rsp_valid.
- rsp_illegal is meaningful only with rsp_valid and is 0 otherwise.
- Writes to read-only CSRs are suppressed only by the illegal check.
  - A read-only CSR accessed without write intent (CSRR, or RS/RC with wdata_zero) is legal and returns its value.
- Writes to CSR index 0x3E (soft reset) are issued normally. The resulting soft reset is the regfile's concern.
- req_valid is ignored outside IDLE. The requester must hold its request until accepted.
- Arithmetic is 32-bit bitwise only. There is no carry and no width extension.

Test Plan:
- Reset low mid-WCSR -> rf_wen drops to 0 at once; after release req_ready=1, no rsp_valid.
- CSRRW csr=0x31, wdata=0xDEADBEEF, rd=5, CSR holds 0x1234:
  - N+3: rf_wen, waddr=0x31, wdata=0xDEADBEEF.
  - N+4: waddr=5, wdata=0x1234.
  - N+5: rsp_rdata=0x1234.
- CSRRS csr=0x2D, wdata=0x0000_00F0, old=0x0F:
  - WCSR writes 0xFF; rsp_rdata=0x0F.
- CSRRC with wdata_zero=1, csr=0x38, rd=0 -> no rf_wen in either write state; rsp_valid at N+5 with the current value.
- CSRRW csr=0x21 (RO) -> rsp_valid at N+1, rsp_illegal=1, rsp_rdata=0, no rf_wen. CSRR csr=0x21 -> legal, returns VENDORID.
- req_csr=0x05 -> illegal at N+1. Back-to-back requests -> second accepted at N+6, not earlier.
